// File: rtl/path_sequencer.sv
// Captures a completed plan from path_planner and hands its nodes, in order,
// to the motion controller one at a time over a valid/ack handshake.
module path_sequencer #(
  parameter int N_SLOTS   = 10,
  parameter int NODE_W    = 5,
  parameter int NODE_NONE = 27
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      plan_done,
  input  logic [N_SLOTS*NODE_W-1:0] final_path,
  input  logic                      node_ack,
  output logic [NODE_W-1:0]         node_out,
  output logic                      node_valid,
  output logic [3:0]                node_idx,
  output logic                      busy,
  output logic                      path_done,
  output logic                      path_empty,
  output logic                      overrun,
  output logic [2:0]                o_dbg_state
);

  // Handshake: node_out/node_idx are held stable while node_valid=1; a transfer
  // happens on a clock edge where node_valid=1 and node_ack=1. node_valid then
  // drops for at least one cycle before the next node is offered.

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_ISSUE    = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_FINISH   = 3'd4
  } state_t;

  localparam logic [NODE_W-1:0] NONE     = NODE_W'(NODE_NONE);
  localparam logic [3:0]        LAST_IDX = 4'(N_SLOTS - 1);

  state_t            r_state;
  logic              r_done_q;
  logic              r_plan_edge;
  logic [NODE_W-1:0] r_path [N_SLOTS];
  logic [3:0]        r_idx;

  logic [NODE_W-1:0] w_cur_slot;
  logic              w_next_last;

  assign o_dbg_state = r_state;

  always_comb begin
    w_cur_slot  = NONE;
    w_next_last = 1'b1;
    if (r_idx <= LAST_IDX) w_cur_slot = r_path[r_idx];
    if (r_idx < LAST_IDX)  w_next_last = (r_path[r_idx + 4'd1] == NONE);
  end

  // done_q resets high: the planner holds done high out of reset and that
  // level must not look like a fresh plan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_q    <= 1'b1;
      r_plan_edge <= 1'b0;
    end else begin
      r_done_q    <= plan_done;
      r_plan_edge <= plan_done & ~r_done_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= 4'd0;
      node_out   <= '0;
      node_valid <= 1'b0;
      node_idx   <= 4'd0;
      busy       <= 1'b0;
      path_done  <= 1'b0;
      path_empty <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < N_SLOTS; i++) r_path[i] <= NONE;
    end else begin
      path_done <= 1'b0;
      // A plan arriving outside IDLE (FINISH included) is dropped, only flagged.
      if (r_plan_edge && (r_state != S_IDLE)) overrun <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (r_plan_edge) begin
            for (int i = 0; i < N_SLOTS; i++) r_path[i] <= final_path[NODE_W*i +: NODE_W];
            path_empty <= 1'b0;
            r_state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          r_idx <= 4'd0;
          if (r_path[0] == NONE) begin
            path_empty <= 1'b1;
            path_done  <= 1'b1;
            busy       <= 1'b0;
            r_state    <= S_FINISH;
          end else begin
            busy    <= 1'b1;
            r_state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          node_out   <= w_cur_slot;
          node_idx   <= r_idx;
          node_valid <= 1'b1;
          r_state    <= S_WAIT_ACK;
        end

        S_WAIT_ACK: begin
          if (node_ack && node_valid) begin
            node_valid <= 1'b0;
            if (w_next_last) begin
              path_done <= 1'b1;
              busy      <= 1'b0;
              r_state   <= S_FINISH;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_state <= S_ISSUE;
            end
          end
        end

        S_FINISH: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/path_sequencer.md
Name: path_sequencer

Overview:
- Sits directly downstream of path_planner and consumes its done and final_path outputs.
- Captures a completed path and releases the nodes one at a time, in traversal order, to the line-follower motion controller over a valid/ack handshake.
- Reports completion, empty paths, and plans that arrive while a path is still being executed.

Parameters:
- N_SLOTS, 10, number of node slots in the path bus.
- NODE_W, 5, bits per node ID.
- NODE_NONE, 27, terminator / unused-slot code.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- plan_done  input  1  path_planner done (level signal).
- final_path  input  N_SLOTS*NODE_W  packed path; slot i at bits [NODE_W*i+NODE_W-1 : NODE_W*i]; slot 0 is the first node to visit.
- node_ack  input  1  motion controller has reached node_out.
- node_out  output  NODE_W  current target node.
- node_valid  output  1  node_out is valid and awaiting ack.
- node_idx  output  4  slot index of node_out.
- busy  output  1  a path is loaded and not finished.
- path_done  output  1  one-cycle pulse when the path completes.
- path_empty  output  1  sticky; the last captured path had NODE_NONE in slot 0.
- overrun  output  1  sticky; a plan arrived while busy.

Behaviour:
- Reset (async assert, sync release) values:
  - node_out=0, node_valid=0, node_idx=0, busy=0, path_done=0, path_empty=0, overrun=0.
  - Path register = all NODE_NONE.
  - FSM = IDLE.
  - done_q (registered plan_done) = 1. The planner holds done high out of reset; resetting done_q to 1 ensures this is not taken as a new plan.
- Plan detection: plan_edge = plan_done & ~done_q. It is registered every cycle. A level held high never produces a second edge.
- FSM states: IDLE, LOAD, ISSUE, WAIT_ACK, FINISH.
  - IDLE: on plan_edge, latch final_path into the path register, clear path_empty, go to LOAD.
  - LOAD (1 cycle): idx=0.
    - If slot 0 == NODE_NONE: set path_empty, go to FINISH.
    - Otherwise set busy=1, go to ISSUE.
  - ISSUE (1 cycle): drive node_out=slot[idx], node_idx=idx, assert node_valid, go to WAIT_ACK.
    - Latency from plan_edge to the first node_valid is 3 cycles (IDLE→LOAD→ISSUE→valid registered).
  - WAIT_ACK: hold node_out, node_idx and node_valid stable until node_ack=1. On the ack cycle:
    - deassert node_valid;
    - if idx==N_SLOTS-1, or slot[idx+1]==NODE_NONE, go to FINISH;
    - otherwise idx+1, go to ISSUE.
  - FINISH (1 cycle): path_done=1 for exactly one cycle, busy=0, go to IDLE. node_out keeps the last node.
- Handshake rules:
  - node_ack is ignored unless node_valid=1.
  - An ack arriving in the ISSUE cycle is not consumed.
  - There is at least one idle cycle between successive valids.
- Plan during execution: a plan_edge in any state other than IDLE sets overrun (sticky until reset). The new plan is discarded and the current path continues unaffected.
- Simultaneous events: plan_edge in the FINISH cycle counts as an overrun (it is not queued).
- Terminator handling: NODE_NONE inside the path ends it. Slots after the first NODE_NONE are never issued, even if they are non-terminator. A full 10-node path ends after slot 9 without needing a terminator.
- Reset mid-operation: all state clears immediately, node_valid drops asynchronously, and done_q=1. A planner done still high after reset does not restart the path.
- node_idx is 4 bits, and its range 0..N_SLOTS-1 is enforced.

Test Plan:
1. Reset release with plan_done=1 held → no node_valid for 50 cycles; busy=0; overrun=0.
2. Normal path: plan_done 0→1 with slots 0..4 = 9,5,2,1,0 and slots 5..9 = 27; ack each node 4 cycles after its valid.
   - First node_valid exactly 3 cycles after the edge.
   - Nodes issued 9,5,2,1,0 with node_idx 0..4.
   - path_done pulses once, 1 cycle after the ack of node 0.
   - busy then falls.
3. Full path of 10 non-27 nodes (1..10) → all 10 issued; node_idx reaches 9; path_done follows without a terminator.
4. Empty path: slot 0 = 27 → no node_valid; path_empty=1; path_done pulses 2 cycles after the edge.
5. Overrun: a new plan_done edge while waiting for the ack of node 2 → overrun=1; remaining nodes come from the original path; the new plan is ignored.
6. Assert rst_n=0 mid-WAIT_ACK while plan_done stays high → node_valid=0 immediately; after release the block stays IDLE until plan_done goes 0 and then 1 again.
